regfile_param: RTL

// - Parametrised, clocked register file for the RISC-V datapath: one synchronous write port, NUM_RD combinational read ports.
// - Generalises the 32x32 two-read register file in data width, depth and read-port count.
// - Adds a sequenced post-reset clear so the storage array needs no reset fanout.
// - Sits between decode (read addresses) and writeback (write port).

---
 rtl/regfile_param_if.sv | 34 +++
 rtl/regfile_param.sv | 116 +++++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_if
// Brief    : Port bundle for regfile_param. It groups the write port, the read
//            ports and the clear-sweep handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     clr_req;
  logic                     busy;
  logic                     wr_drop;

  // Datapath side: decode/writeback drive addresses, data and clear requests
  modport master (
    output we, waddr, wdata, raddr, clr_req,
    input  rdata, busy, wr_drop
  );

  // Register file side
  modport slave (
    input  we, waddr, wdata, raddr, clr_req,
    output rdata, busy, wr_drop
  );
endinterface
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Brief    : Parametrised register file with one synchronous write port and
//            NUM_RD combinational read ports. A sequenced clear sweep runs
//            after reset or on request, so the storage array needs no reset.
//            When REGFILE_BYPASS_EN is defined, write data is forwarded to
//            matching read ports in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  regfile_param_if.slave  bus_io
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] C_ST_IDLE  = 1'b0;
  localparam logic [0:0] C_ST_CLEAR = 1'b1;

  // The counter is one bit wider than an address, so DEPTH fits without wrapping
  localparam logic [ADDR_W:0] C_CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] C_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic busy_w;
  logic wr_zero_w;
  logic wr_en_w;

  assign busy_w    = (state_q == C_ST_CLEAR);
  assign wr_zero_w = (ZERO_REG != 0) && (bus_io.waddr == '0);
  assign wr_en_w   = !busy_w && bus_io.we && !wr_zero_w;

  // Sweep sequencing: advance the clear pointer, leave after the last entry, honour clr_req only while idle
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    // Writes to a hardwired-zero entry are discarded silently, even mid-sweep
    wr_drop_d = busy_w && bus_io.we && !wr_zero_w;
    if (busy_w) begin
      clr_cnt_d = clr_cnt_q + C_CNT_ONE;
      if (clr_cnt_q == C_CNT_LAST) begin
        state_d = C_ST_IDLE;
      end
    end else if (bus_io.clr_req) begin
      state_d   = C_ST_CLEAR;
      clr_cnt_d = '0;
    end
  end

  // Control state: reset sends the block straight into a fresh sweep from entry 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= C_ST_CLEAR;
      clr_cnt_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage is not reset: the sweep zeroes one entry per cycle, otherwise accepted writes land here
  always_ff @(posedge clk) begin
    if (busy_w) begin
      mem_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
    end else if (wr_en_w) begin
      mem_q[bus_io.waddr] <= bus_io.wdata;
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra_w;
      logic [DATA_W-1:0] rd_w;

      assign ra_w = bus_io.raddr[k*ADDR_W +: ADDR_W];

      // Read mux: stored value, optional write-through, then zero-reg and busy masking
      always_comb begin
        rd_w = mem_q[ra_w];
`ifdef REGFILE_BYPASS_EN
        if (bus_io.we && (bus_io.waddr == ra_w)) begin
          rd_w = bus_io.wdata;
        end
`else
`endif
        if ((ZERO_REG != 0) && (ra_w == '0)) begin
          rd_w = '0;
        end
        // Busy masking also covers forwarding, because writes are dropped during a sweep
        if (busy_w) begin
          rd_w = '0;
        end
      end

      assign bus_io.rdata[k*DATA_W +: DATA_W] = rd_w;
    end
  endgenerate

  assign bus_io.busy    = busy_w;
  assign bus_io.wr_drop = wr_drop_q;

endmodule
`default_nettype wire
